// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: prescaled count tick, start/stop/lap/clear FSM and lap-freezable display copy.
// Optional feature: define STOPWATCH_OVF_STOP_EN to pause and latch a sticky flag on 9999->0000 rollover.
module stopwatch_ctrl #(
    parameter int PRESCALE = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_stop,
    input  logic        lap_reset,
    input  logic [15:0] digits_in,
    input  logic        top_carry,
    output logic        cnt_en,
    output logic        cnt_clr,
    output logic [15:0] disp,
    output logic [1:0]  state,
    output logic        overflow
);

    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } state_t;

    state_t        cur;
    state_t        nxt;
    logic [PW-1:0] presc;
    logic [15:0]   lap_q;
    logic          ovf_q;
    logic          ovf_hit;
    logic          advance;

`ifdef STOPWATCH_OVF_STOP_EN
    assign ovf_hit = cnt_en & top_carry;
`else
    logic unused_top_carry;
    assign unused_top_carry = top_carry;
    assign ovf_hit = 1'b0;
    assign ovf_q   = 1'b0;
`endif

    assign state    = cur;
    assign overflow = ovf_q;

    // start_stop outranks lap_reset; a rollover forces PAUSE over both.
    always_comb begin
        nxt = cur;
        if (ovf_hit) begin
            nxt = PAUSE;
        end else begin
            case (cur)
                IDLE: begin
                    if (start_stop) nxt = RUN;
                end
                RUN: begin
                    if (start_stop)     nxt = PAUSE;
                    else if (lap_reset) nxt = LAP;
                end
                LAP: begin
                    if (start_stop)     nxt = PAUSE;
                    else if (lap_reset) nxt = RUN;
                end
                PAUSE: begin
                    if (start_stop && !ovf_q) nxt = RUN;
                    else if (lap_reset)       nxt = IDLE;
                end
            endcase
        end
    end

    // The prescaler only advances when counting both now and next cycle, so a
    // pause freezes the phase at the value seen when start_stop was sampled.
    assign advance = ((cur == RUN) || (cur == LAP)) && ((nxt == RUN) || (nxt == LAP));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur     <= IDLE;
            presc   <= '0;
            cnt_en  <= 1'b0;
            cnt_clr <= 1'b1;
            disp    <= '0;
            lap_q   <= '0;
`ifdef STOPWATCH_OVF_STOP_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            cur     <= nxt;
            cnt_en  <= advance && (presc == PMAX);
            cnt_clr <= (cur == PAUSE) && (nxt == IDLE);

            if (cur == IDLE) begin
                presc <= '0;
            end else if (advance) begin
                presc <= (presc == PMAX) ? '0 : presc + 1'b1;
            end

            if ((nxt == LAP) && (cur != LAP)) begin
                lap_q <= digits_in;
                disp  <= digits_in;
            end else if (nxt == LAP) begin
                disp  <= lap_q;
            end else begin
                disp  <= digits_in;
            end

`ifdef STOPWATCH_OVF_STOP_EN
            if (ovf_hit) begin
                ovf_q <= 1'b1;
            end else if ((cur == PAUSE) && (nxt == IDLE)) begin
                ovf_q <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Sequencing controller for a cascaded chain of enable-driven BCD digit counters (4 digits, units first). It generates the chain's count-enable tick from the system clock through a programmable prescaler. It runs a start/stop/lap/reset state machine driven by single-cycle button pulses and supplies a registered, lap-freezable copy of the digit values to the display path. Sits between the debounced push-button logic and the BCD counter chain / 7-segment driver.

## Interface
- PRESCALE, default 50_000_000: clock cycles per count tick; legal range 2..2^26.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_stop  in  1  single-cycle pulse; toggles run/pause.
- lap_reset  in  1  single-cycle pulse; lap freeze/release while running, clear while paused.
- digits_in  in  16  BCD digits from the counter chain; [3:0] units … [15:12] thousands.
- top_carry  in  1  carryout of the thousands digit (high when that digit is 9 and its enable is high).
- cnt_en  out  1  count-enable tick to the units digit; one-cycle pulse.
- cnt_clr  out  1  synchronous clear to every digit of the chain.
- disp  out  16  display value.
- state  out  2  FSM state: IDLE=00, RUN=01, PAUSE=10, LAP=11.
- overflow  out  1  sticky overflow flag (see Configuration).

## Operation
- Prescaler: counter of width clog2(PRESCALE), counts 0..PRESCALE-1 only in RUN or LAP. It holds its value in PAUSE and is cleared in IDLE.
- cnt_en = 1 for exactly the cycle in which the prescaler equals PRESCALE-1 and state is RUN or LAP. It is never high in IDLE or PAUSE.
- FSM transitions, evaluated each clock:
  - IDLE: start_stop → RUN; lap_reset is ignored.
  - RUN: start_stop → PAUSE; lap_reset → LAP, capturing digits_in into the lap register.
  - LAP: start_stop → PAUSE, freeze released; lap_reset → RUN, freeze released. Counting continues in LAP.
  - PAUSE: start_stop → RUN; lap_reset → IDLE, with cnt_clr pulsed and overflow cleared.
- Simultaneous start_stop and lap_reset: start_stop has priority; lap_reset is dropped.
- disp = lap register while in LAP, otherwise digits_in delayed by one register stage.
- cnt_clr: registered output. It is high for one cycle on the PAUSE→IDLE transition, and high while rst is low.

## Timing
- Reset values: state=IDLE (00), cnt_en=0, cnt_clr=1, disp=0x0000, overflow=0, prescaler=0, lap register=0x0000.
- First posedge after rst is released: cnt_clr drops to 0.
- cnt_en is registered. The first tick after IDLE→RUN arrives PRESCALE cycles after the cycle in which start_stop was sampled.
- Pausing then resuming preserves prescaler phase. The tick arrives after the remaining cycles of the interrupted period.
- State change is visible on `state` the cycle after the input pulse is sampled.
- disp latency from digits_in is 1 cycle outside LAP. On entry to LAP, disp shows the digits_in value sampled in the same cycle as lap_reset.
- cnt_clr is asserted the cycle after lap_reset is sampled in PAUSE. The chain reads 0000 one cycle after that.
- Overflow condition: top_carry=1 while cnt_en=1.

## Configuration
- Macro STOPWATCH_OVF_STOP_EN.
- Defined:
  - On the overflow condition, overflow is set (sticky) and the FSM goes to PAUSE in the next cycle. LAP freeze is released.
  - The chain wraps to 0000 on that tick; the display therefore shows 0000 with overflow=1.
  - While overflow=1, start_stop in PAUSE is ignored. Only lap_reset (→IDLE) leaves PAUSE.
- Undefined:
  - The overflow condition is ignored; the chain wraps 9999→0000 and counting continues.
  - overflow is tied to 0.

## Test plan
- Reset and first tick (PRESCALE=4): hold rst low, release, pulse start_stop → cnt_clr=1 during reset, then 0; state=01; cnt_en pulses every 4 cycles, first pulse 4 cycles after the sampled start_stop.
- Pause preserves phase (PRESCALE=4): start_stop at prescaler=2 in RUN → PAUSE, no cnt_en for 10 cycles; start_stop again → next cnt_en exactly 2 cycles later.
- Lap (digits_in incrementing via model chain): RUN at 0012, pulse lap_reset → state=11, disp frozen at 0012 while the chain reaches 0015; lap_reset → state=01, disp follows the chain with 1-cycle delay.
- Clear: in PAUSE at 0347, pulse lap_reset → cnt_clr high for exactly 1 cycle, state=00, chain 0000; further lap_reset pulses in IDLE → no cnt_clr.
- Priority: start_stop and lap_reset high in the same RUN cycle → state=10, lap register unchanged.
- Overflow: chain preset to 9999, RUN, tick → with STOPWATCH_OVF_STOP_EN: overflow=1, state=10, start_stop ignored, lap_reset → IDLE, overflow=0. Without the macro: chain 0000, state stays 01, overflow=0.
